// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, imem req/ack handshake and a
// prefetch FIFO feeding decode. Redirects flush the FIFO and squash in-flight fetches.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             push, pop, flush;
    logic [CNT_W-1:0] count_after_pop;
    logic             space_now, space_after_push;
    logic [31:0]      redirect_tgt, req_addr_inc;

    assign imem_req   = (state_q == REQ) || (state_q == DROP);
    assign imem_addr  = req_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = fifo_q[rd_ptr_q].word;
    assign inst_pc    = fifo_q[rd_ptr_q].pc;

    assign pop             = inst_valid && inst_ready;
    assign count_after_pop = count_q - CNT_W'(pop);
    // Credit counts this cycle's pop, so a full FIFO being drained can still issue.
    assign space_now        = count_after_pop < CNT_W'(DEPTH);
    assign space_after_push = count_after_pop < CNT_W'(DEPTH - 1);
    assign redirect_tgt     = redirect_pc & 32'hFFFF_FFFC;
    assign req_addr_inc     = req_addr_q + 32'd4;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave one
        // unassigned and infer a latch.
        state_d    = state_q;
        req_addr_d = req_addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_tgt;
                    req_addr_d = redirect_tgt;
                    state_d    = REQ;
                end else if (space_now) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_tgt;
                    if (imem_ack) begin
                        req_addr_d = redirect_tgt;
                    end else begin
                        // The outstanding request cannot be retracted; wait out its ack.
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = req_addr_inc;
                    if (space_after_push) begin
                        req_addr_d = req_addr_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_tgt;
                    if (imem_ack) begin
                        req_addr_d = redirect_tgt;
                        state_d    = REQ;
                    end
                end else if (imem_ack) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is cleared too, so the head outputs read zero throughout reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{pc: req_addr_q, word: imem_rdata};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle datapath. It replaces the bare program_counter/pc_adder pair, and decode consumes its output.
- It generates sequential fetch addresses and talks to instruction memory over a req/ack handshake.
- Fetched {pc, instruction} pairs are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake.
- Branch/jump redirects flush the FIFO and discard any in-flight fetch.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address; word aligned, bits [1:0]=0
- imem_ack  input  1  memory returns data this cycle; the transfer completes on imem_req && imem_ack
- imem_rdata  input  32  instruction word; valid when imem_ack=1
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0
- inst_valid  output  1  FIFO head valid
- inst  output  32  head instruction
- inst_pc  output  32  head instruction address
- inst_ready  input  1  decode accepts the head; a pop occurs on inst_valid && inst_ready

Behaviour:
- State: FSM {IDLE, REQ, DROP}.
- Registers:
  - req_addr: drives imem_addr.
  - fetch_pc: next address to fetch.
  - FIFO storage, with wr_ptr, rd_ptr and count (0..DEPTH).
- Reset (async, while reset=0):
  - state=IDLE; req_addr=fetch_pc=RESET_PC; count=0; pointers=0; all FIFO entries zeroed.
  - Outputs during reset: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Combinational outputs:
  - imem_req = (state==REQ || state==DROP).
  - inst_valid = (count!=0).
  - inst and inst_pc come from the head entry, with zero latency.
- Credit: space = (count - pop + 0) < DEPTH, evaluated using this cycle's pop.
- IDLE:
  - Redirect: fetch_pc=req_addr=redirect_pc, flush, go to REQ.
  - Otherwise, if space: req_addr=fetch_pc, go to REQ.
  - First request is visible in the 2nd cycle after reset release.
- REQ:
  - imem_addr is held stable until ack.
  - On ack without redirect:
    - Push {req_addr, imem_rdata}; fetch_pc=req_addr+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
    - If space remains after push and pop: req_addr=fetch_pc+4 and stay in REQ. This gives 1 fetch/cycle with a zero-wait memory.
    - Otherwise go to IDLE.
  - Redirect without ack: flush; fetch_pc=redirect_pc; go to DROP. req_addr is unchanged because the request may not be retracted.
  - Redirect with ack in the same cycle: ack data is discarded (not pushed); flush; req_addr=fetch_pc=redirect_pc; go to REQ.
- DROP:
  - imem_req stays 1 with the old req_addr.
  - On ack: data is discarded; req_addr=fetch_pc; go to REQ.
  - A further redirect updates fetch_pc, and the latest redirect wins. Redirect with ack applies the new target directly.
- Flush:
  - count=0 and rd_ptr=wr_ptr at the next edge.
  - A pop in the same cycle as a redirect is accepted by decode but has no further effect; flush wins.
  - inst_valid=0 in the cycle after a redirect.
- FIFO:
  - Push and pop in the same cycle: count unchanged. This is legal when full, but the FSM never pushes when no space exists.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- Ordering and ack:
  - Entries leave strictly in fetch order; inst_pc increments by 4 between consecutive non-redirected entries.
  - imem_ack while imem_req=0 is ignored.
- Reset asserted mid-transaction: immediate return to reset values. Any in-flight ack after release is ignored, because the state is IDLE and req=0.

Test Plan:
- Reset release, imem_ack=1 always, inst_ready=1, RESET_PC=0 -> imem_req rises in the 2nd cycle; inst_pc sequence is 0,4,8,C, one per cycle; inst matches the memory words.
- inst_ready=0 with zero-wait memory -> exactly 4 pushes (pc 0..C); count=4; imem_req=0. Raising inst_ready then pops 0 first and fetching resumes at 0x10.
- Memory with 3-cycle ack latency, redirect to 0x100 in the 2nd wait cycle -> imem_addr is held at the old address until ack; that data is never presented; the next imem_addr is 0x100; the first inst_pc after redirect is 0x100.
- Redirect to 0x203 coinciding with ack of 0x8 -> 0x8 is not pushed; FIFO is empty next cycle; the next fetch address is 0x200.
- Redirect to 0xFFFF_FFF8 with a streaming memory -> inst_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert reset for 1 cycle mid-stream with FIFO count=3 -> inst_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC.
